// File: rtl/v_issue_ctrl.sv
// Buffers decoded vector instructions and issues them one at a time to the vector unit,
// retiring on DONE, with a BUSY watchdog, pipeline flush and a reduction writeback hazard.
module v_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [103:0] s_payload,
  input  logic         s_flush,
  input  logic         stall,
  input  logic         DONE,
  input  logic         XRF_WE,
  input  logic [4:0]   XRF_ADDR,
  output logic         I_start,
  output logic [2:0]   I_id,
  output logic         I_clear,
  output logic [4:0]   I_vs1,
  output logic [4:0]   I_vs2,
  output logic [4:0]   I_vd,
  output logic [31:0]  I_RS1,
  output logic [31:0]  I_RS2,
  output logic [4:0]   I_uimm5,
  output logic [7:0]   I_funct,
  output logic [1:0]   I_permute,
  output logic         I_mask_en,
  output logic [1:0]   I_ALUSrc,
  output logic         I_dmr,
  output logic         I_dmw,
  output logic         I_reg_we,
  output logic         I_mem_reg,
  output logic         I_Xout,
  output logic [1:0]   I_mode_lsu,
  output logic         v_busy,
  output logic         retired,
  output logic         x_pending,
  output logic [4:0]   x_rd,
  output logic         err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [9:0]    TO   = 10'(TIMEOUT);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t        state;
  logic [103:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [103:0]  cur;
  logic [9:0]    wdog;
  logic [2:0]    id_cnt;
  logic          push;
  logic          pop;
  logic          retire;
  logic          abort;

  assign s_ready = count < FULL;
  assign v_busy  = (state != IDLE) || (count != '0);
  assign push    = s_valid && s_ready && !s_flush;
  assign retire  = (state == BUSY) && DONE && !s_flush;
  assign abort   = (state == BUSY) && !DONE && (wdog == TO) && !s_flush;
  assign pop     = retire || abort;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_payload;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cur       <= '0;
      wdog      <= '0;
      id_cnt    <= '0;
      I_start   <= 1'b0;
      I_id      <= '0;
      I_clear   <= 1'b0;
      retired   <= 1'b0;
      x_pending <= 1'b0;
      x_rd      <= '0;
      err       <= 1'b0;
    end else begin
      I_start <= 1'b0;
      I_clear <= 1'b0;
      retired <= 1'b0;
      if (XRF_WE && (XRF_ADDR == x_rd)) x_pending <= 1'b0;
      if (s_flush) begin
        state     <= IDLE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        id_cnt    <= '0;
        x_pending <= 1'b0;
        I_clear   <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
        case (state)
          IDLE: begin
            if ((count != '0) && !stall && !x_pending) begin
              state   <= ISSUE;
              I_start <= 1'b1;
              I_id    <= id_cnt;
              cur     <= mem[rd_ptr];
              wdog    <= '0;
              // Bit 2 is Xout: the reduction's scalar result lands in vd.
              if (mem[rd_ptr][2]) begin
                x_pending <= 1'b1;
                x_rd      <= mem[rd_ptr][93:89];
              end
            end
          end
          ISSUE: begin
            state <= BUSY;
            wdog  <= wdog + 10'd1;
          end
          BUSY: begin
            if (retire) begin
              state   <= IDLE;
              retired <= 1'b1;
              id_cnt  <= id_cnt + 3'd1;
            end else if (abort) begin
              state     <= IDLE;
              I_clear   <= 1'b1;
              err       <= 1'b1;
              x_pending <= 1'b0;
              id_cnt    <= id_cnt + 3'd1;
            end else begin
              wdog <= wdog + 10'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign I_vs1      = cur[103:99];
  assign I_vs2      = cur[98:94];
  assign I_vd       = cur[93:89];
  assign I_RS1      = cur[88:57];
  assign I_RS2      = cur[56:25];
  assign I_uimm5    = cur[24:20];
  assign I_funct    = cur[19:12];
  assign I_permute  = cur[11:10];
  assign I_mask_en  = cur[9];
  assign I_ALUSrc   = cur[8:7];
  assign I_dmr      = cur[6];
  assign I_dmw      = cur[5];
  assign I_reg_we   = cur[4];
  assign I_mem_reg  = cur[3];
  assign I_Xout     = cur[2];
  assign I_mode_lsu = cur[1:0];
endmodule
